// File: rtl/icape2_pkg.sv
// icape2_pkg: parser state encoding, sync/NOP words, configuration register
// addresses, CMD opcodes and packet header field layout for the ICAPE2 model.
package icape2_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC,
        ST_HDR,
        ST_WDATA,
        ST_RDATA
    } state_e;

    localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
    localparam logic [31:0] NOP_WORD    = 32'h20000000;

    localparam logic [4:0]  ADDR_CMD    = 5'h04;
    localparam logic [4:0]  ADDR_STAT   = 5'h07;
    localparam logic [4:0]  ADDR_IDCODE = 5'h0C;
    localparam logic [4:0]  ADDR_WBSTAR = 5'h10;

    localparam logic [4:0]  CMD_IPROG   = 5'h0F;
    localparam logic [4:0]  CMD_DESYNC  = 5'h0D;

    localparam logic [2:0]  HDR_TYPE1   = 3'b001;
    localparam logic [2:0]  HDR_TYPE2   = 3'b010;

    localparam logic [1:0]  OP_NOP      = 2'b00;
    localparam logic [1:0]  OP_READ     = 2'b01;
    localparam logic [1:0]  OP_WRITE    = 2'b10;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned OP_W        = 2;
    localparam int unsigned WC1_W       = 11;
    localparam int unsigned WC2_W       = 27;

endpackage

// File: rtl/icape2_bitswap.sv
// icape2_bitswap: reverses bit order inside each byte of a 32-bit word,
// matching the ICAP bus bit ordering. Self-inverse.
module icape2_bitswap (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // Per-byte bit reversal.
    always_comb begin
        dout = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                dout[8*b + k] = din[8*b + 7 - k];
            end
        end
    end

endmodule

// File: rtl/icape2.sv
// icape2: behavioural ICAPE2 configuration port. Detects the sync word,
// parses type-1/type-2 write packets, holds WBSTAR and executes IPROG/DESYNC.
// Optional readback of WBSTAR/CMD/IDCODE/STAT when ICAPE2_READBACK_EN is defined;
// otherwise read headers are ignored and O is tied to zero.
module icape2 import icape2_pkg::*; #(
    parameter              ICAP_WIDTH = "X32",
    parameter logic [31:0] DEVICE_ID  = 32'h0362D093
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CSIB,
    input  logic        RDWRB,
    input  logic [31:0] I,
    output logic [31:0] O,
    output logic        synced,
    output logic [31:0] wbstar,
    output logic        iprog
);

    if (ICAP_WIDTH != "X32") begin : g_bad_width
        $fatal(1, "icape2: only ICAP_WIDTH \"X32\" is supported");
    end

`ifdef ICAPE2_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WC2_W-1:0]   wc_q, wc_d;
    logic [31:0]        wbstar_q, wbstar_d;
    logic               iprog_q, iprog_d;
    logic [31:0]        w;

    icape2_bitswap u_swap_i (
        .din  (I),
        .dout (w)
    );

    assign synced = (state_q != ST_UNSYNC);
    assign wbstar = wbstar_q;
    assign iprog  = iprog_q;

`ifdef ICAPE2_READBACK_EN
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] o_raw_q, o_raw_d;
    logic [31:0] rd_value;

    // Readback source selected by the latched register address.
    always_comb begin
        rd_value = '0;
        case (addr_q)
            ADDR_WBSTAR: rd_value = wbstar_q;
            ADDR_CMD:    rd_value = cmd_q;
            ADDR_IDCODE: rd_value = DEVICE_ID;
            ADDR_STAT:   rd_value = {31'b0, synced};
            default:     rd_value = '0;
        endcase
    end

    icape2_bitswap u_swap_o (
        .din  (o_raw_q),
        .dout (O)
    );

    // Readback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            o_raw_q <= '0;
        end else begin
            cmd_q   <= cmd_d;
            o_raw_q <= o_raw_d;
        end
    end
`else
    assign O = '0;
`endif

    // Packet parser: next state, packet bookkeeping and register writes.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        op_d     = op_q;
        wc_d     = wc_q;
        wbstar_d = wbstar_q;
        iprog_d  = 1'b0;
`ifdef ICAPE2_READBACK_EN
        cmd_d    = cmd_q;
        o_raw_d  = o_raw_q;
`endif
        if (!CSIB) begin
            case (state_q)
                ST_UNSYNC: begin
                    if (!RDWRB && w == SYNC_WORD) state_d = ST_HDR;
                end
                ST_HDR: begin
                    if (!RDWRB) begin
                        if (w[31:29] == HDR_TYPE1) begin
                            if (w[28:27] == OP_WRITE || (READBACK && w[28:27] == OP_READ)) begin
                                op_d   = w[28:27];
                                addr_d = w[17:13];
                                wc_d   = {{(WC2_W-WC1_W){1'b0}}, w[10:0]};
                                if (w[10:0] != '0) begin
                                    state_d = (w[28:27] == OP_READ) ? ST_RDATA : ST_WDATA;
                                end
                            end
                        end else if (w[31:29] == HDR_TYPE2 && w[26:0] != '0) begin
                            if (op_q == OP_WRITE) begin
                                wc_d    = w[26:0];
                                state_d = ST_WDATA;
                            end else if (READBACK && op_q == OP_READ) begin
                                wc_d    = w[26:0];
                                state_d = ST_RDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (!RDWRB) begin
                        wc_d = wc_q - 27'd1;
                        if (wc_q == 27'd1) state_d = ST_HDR;
                        if (addr_q == ADDR_WBSTAR) wbstar_d = w;
                        if (addr_q == ADDR_CMD) begin
`ifdef ICAPE2_READBACK_EN
                            cmd_d = w;
`endif
                            if (w[4:0] == CMD_IPROG) begin
                                iprog_d = 1'b1;
                                state_d = ST_UNSYNC;
                            end else if (w[4:0] == CMD_DESYNC) begin
                                state_d = ST_UNSYNC;
                            end
                        end
                    end else begin
                        // Read strobe during a write packet aborts it.
                        wc_d    = '0;
                        state_d = ST_HDR;
                    end
                end
`ifdef ICAPE2_READBACK_EN
                ST_RDATA: begin
                    if (RDWRB) begin
                        o_raw_d = rd_value;
                        wc_d    = wc_q - 27'd1;
                        if (wc_q == 27'd1) state_d = ST_HDR;
                    end
                end
`endif
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    // Parser state and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_UNSYNC;
            addr_q   <= '0;
            op_q     <= OP_NOP;
            wc_q     <= '0;
            wbstar_q <= '0;
            iprog_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            wc_q     <= wc_d;
            wbstar_q <= wbstar_d;
            iprog_q  <= iprog_d;
        end
    end

endmodule

// File: tb/tb_icape2.sv
// tb_icape2: directed-vector bench for icape2 with a packet-level reference
// model checked on every falling clock edge, plus literal spot checks.
module tb_icape2;

`ifdef ICAPE2_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CSIB = 1'b1;
    logic        RDWRB = 1'b0;
    logic [31:0] I = '0;
    logic [31:0] O;
    logic        synced;
    logic [31:0] wbstar;
    logic        iprog;

    icape2 #(.ICAP_WIDTH("X32"), .DEVICE_ID(32'h0362D093)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .CSIB   (CSIB),
        .RDWRB  (RDWRB),
        .I      (I),
        .O      (O),
        .synced (synced),
        .wbstar (wbstar),
        .iprog  (iprog)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_iprog = 0;
    bit run = 1'b0;

    // Reference model state, expressed per packet rather than per FSM state.
    bit          m_synced;
    int          m_left;
    bit          m_reading;
    logic [4:0]  m_addr;
    logic [1:0]  m_op;
    logic [31:0] m_wbstar, m_cmd, m_o;
    bit          m_iprog;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                r[8*b + k] = x[8*b + 7 - k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [4:0] a);
        case (a)
            5'h10:   return m_wbstar;
            5'h04:   return m_cmd;
            5'h0C:   return 32'h0362D093;
            5'h07:   return {31'b0, m_synced};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_synced = 0; m_left = 0; m_reading = 0; m_addr = '0; m_op = '0;
        m_wbstar = '0; m_cmd = '0; m_o = '0; m_iprog = 0;
    endtask

    task automatic model_step(input logic cs, input logic rw, input logic [31:0] w);
        m_iprog = 0;
        if (cs) return;
        if (rw) begin
            if (m_synced && m_left > 0 && !m_reading) m_left = 0;
            else if (m_synced && m_left > 0 && m_reading) begin
                m_o = bswap(reg_value(m_addr));
                m_left--;
            end
        end else if (!m_synced) begin
            if (w == 32'hAA995566) begin m_synced = 1; m_left = 0; end
        end else if (m_left > 0) begin
            if (!m_reading) begin
                m_left--;
                if (m_addr == 5'h10) m_wbstar = w;
                if (m_addr == 5'h04) begin
                    m_cmd = w;
                    if (w[4:0] == 5'h0F) begin m_iprog = 1; m_synced = 0; m_left = 0; end
                    else if (w[4:0] == 5'h0D) begin m_synced = 0; m_left = 0; end
                end
            end
        end else if (w[31:29] == 3'b001) begin
            if (w[28:27] == 2'b10 || (RB && w[28:27] == 2'b01)) begin
                m_op = w[28:27];
                m_addr = w[17:13];
                m_left = int'(w[10:0]);
                m_reading = (w[28:27] == 2'b01);
            end
        end else if (w[31:29] == 3'b010) begin
            if (m_op == 2'b10 || (RB && m_op == 2'b01)) begin
                m_left = int'(w[26:0]);
                m_reading = (m_op == 2'b01);
            end
        end
    endtask

    // Model advances on the same edges as the DUT; reset is asynchronous.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(CSIB, RDWRB, bswap(I));
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (run) begin
            chk("synced", 32'(synced), 32'(m_synced));
            chk("wbstar", wbstar, m_wbstar);
            chk("iprog", 32'(iprog), 32'(m_iprog));
            chk("O", O, m_o);
            if (iprog === 1'b1) n_iprog++;
        end
    end

    task automatic send(input logic [31:0] word);
        CSIB = 1'b0; RDWRB = 1'b0; I = bswap(word);
        @(negedge clk);
    endtask

    task automatic send_held(input logic [31:0] word);
        CSIB = 1'b1; RDWRB = 1'b0; I = bswap(word);
        @(negedge clk);
    endtask

    task automatic rd_cycle();
        CSIB = 1'b0; RDWRB = 1'b1; I = '0;
        @(negedge clk);
    endtask

    task automatic idle();
        CSIB = 1'b1; RDWRB = 1'b0; I = bswap(32'h20000000);
        @(negedge clk);
    endtask

    task automatic do_reset();
        CSIB = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [31:0] mb [7] = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                            32'h00010000, 32'h30008001, 32'h0000000F};
    int base;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run = 1'b1;
        chk("rst_synced", 32'(synced), 32'h0);
        chk("rst_wbstar", wbstar, 32'h0);
        chk("rst_iprog", 32'(iprog), 32'h0);
        chk("rst_O", O, 32'h0);

        // Multiboot sequence.
        base = n_iprog;
        for (int i = 0; i < 7; i++) send(mb[i]);
        chk("mb_iprog_pulse", 32'(iprog), 32'h1);
        send(32'h20000000);
        chk("mb_iprog_end", 32'(iprog), 32'h0);
        chk("mb_synced", 32'(synced), 32'h0);
        send(32'h20000000);
        chk("mb_wbstar", wbstar, 32'h00010000);
        chk("mb_iprog_once", n_iprog - base, 1);

        // Same sequence with chip select inactive.
        do_reset();
        base = n_iprog;
        for (int i = 0; i < 7; i++) send_held(mb[i]);
        idle(); idle();
        chk("cs_wbstar", wbstar, 32'h0);
        chk("cs_synced", 32'(synced), 32'h0);
        chk("cs_no_iprog", n_iprog - base, 0);

        // DESYNC then a write that must be ignored.
        send(32'hAA995566); send(32'h30020001); send(32'hCAFEF00D);
        send(32'h30008001); send(32'h0000000D);
        chk("ds_synced", 32'(synced), 32'h0);
        send(32'h30020001); send(32'h12345678);
        chk("ds_wbstar", wbstar, 32'hCAFEF00D);

        // Two-word write: last word wins; next word is a header.
        send(32'hAA995566); send(32'h30020002); send(32'h11111111); send(32'h22222222);
        chk("mw_wbstar", wbstar, 32'h22222222);
        chk("mw_synced", 32'(synced), 32'h1);
        send(32'h30008001); send(32'h0000000D);
        chk("mw_hdr_after", 32'(synced), 32'h0);

        // Readback of IDCODE, STAT and WBSTAR.
        send(32'hAA995566); send(32'h28018001); rd_cycle();
        chk("rb_idcode", O, RB ? 32'hC0460BC9 : 32'h0);
        send(32'h2800E001); rd_cycle();
        chk("rb_stat", O, RB ? 32'h00000080 : 32'h0);
        send(32'h28020001); rd_cycle();
        chk("rb_wbstar", O, RB ? 32'h44444444 : 32'h0);

        // Read strobe aborts a write packet.
        send(32'h30020002); send(32'hAAAAAAAA); rd_cycle();
        send(32'h30020001); send(32'h55555555);
        chk("ab_wbstar", wbstar, 32'h55555555);

        // CSIB=1 holds state in the middle of a packet.
        send(32'h30020002); send(32'h01010101);
        send_held(32'h30008001); send_held(32'h0000000D);
        send(32'h02020202);
        chk("hold_wbstar", wbstar, 32'h02020202);
        chk("hold_synced", 32'(synced), 32'h1);

        // Type-1 with zero count followed by a type-2 header.
        send(32'h30020000); send(32'h50000001); send(32'hABCDEF01);
        chk("t2_wbstar", wbstar, 32'hABCDEF01);

        // Reset in the middle of a write packet.
        send(32'h30020003); send(32'h77777777);
        do_reset();
        send(32'h88888888); send(32'h99999999);
        chk("mr_synced", 32'(synced), 32'h0);
        chk("mr_wbstar", wbstar, 32'h0);
        idle();

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
